// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: one digit per cycle, LSD first.
// Produces (a - b) mod 10^DIGITS, a borrow flag and an invalid-operand flag.
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  borrow,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [IDX_W-1:0] idx;
  logic             brw;
  logic             err_cap;
  logic             operand_bad;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       digit;
  logic [4:0]       diff;
  logic             brw_next;

  always_comb begin
    operand_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) operand_bad = 1'b1;
    end
  end

  // A negative 5-bit difference wraps its low nibble, so adding 10 mod 16 yields the BCD digit.
  always_comb begin
    a_nib    = a_reg[{idx, 2'b00} +: 4];
    b_nib    = b_reg[{idx, 2'b00} +: 4];
    diff     = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, brw};
    brw_next = diff[4];
    digit    = diff[4] ? (diff[3:0] + 4'd10) : diff[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      idx     <= '0;
      brw     <= 1'b0;
      err_cap <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      borrow  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            idx     <= '0;
            brw     <= 1'b0;
            err_cap <= operand_bad;
            busy    <= 1'b1;
            result  <= '0;
            borrow  <= 1'b0;
            err     <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          // Invalid operands leave the result at zero but keep the normal latency.
          if (!err_cap) result[{idx, 2'b00} +: 4] <= digit;
          brw <= brw_next;
          if (idx == LAST_IDX) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            borrow <= err_cap ? 1'b0 : brw_next;
            err    <= err_cap;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Scoreboard bench for bcd_sub_serial: DIGITS=4 and DIGITS=1 instances checked
// against an integer-arithmetic reference model.
module tb_bcd_sub_serial;

  typedef struct {
    logic [31:0] res;
    logic        brw;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start4 = 1'b0;
  logic [15:0] a4 = '0;
  logic [15:0] b4 = '0;
  logic        busy4, done4, brw4, err4;
  logic [15:0] res4;

  logic        start1 = 1'b0;
  logic [3:0]  a1 = '0;
  logic [3:0]  b1 = '0;
  logic        busy1, done1, brw1, err1;
  logic [3:0]  res1;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q4[$];
  exp_t q1[$];
  exp_t got4, got1;
  logic prev_done4 = 1'b0;
  logic prev_done1 = 1'b0;

  bcd_sub_serial #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .borrow(brw4), .err(err4)
  );

  bcd_sub_serial #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(res1), .borrow(brw1), .err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: decode to integers, subtract modulo 10^nd, re-encode as BCD.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int nd, input int accept);
    exp_t   e;
    longint va = 0;
    longint vb = 0;
    longint modv = 1;
    longint dv;
    logic [3:0] na, nb;
    e.err = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      na = a[4*i +: 4];
      nb = b[4*i +: 4];
      if (na > 4'd9 || nb > 4'd9) e.err = 1'b1;
      va = va * 10 + longint'(na);
      vb = vb * 10 + longint'(nb);
      modv = modv * 10;
    end
    e.res = '0;
    e.brw = 1'b0;
    e.cyc = accept + nd;
    if (!e.err) begin
      dv = va - vb;
      if (dv < 0) begin
        dv = dv + modv;
        e.brw = 1'b1;
      end
      for (int i = 0; i < nd; i++) begin
        e.res[4*i +: 4] = 4'(dv % 10);
        dv = dv / 10;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] randBcd(input int nd);
    logic [31:0] v = '0;
    int p;
    for (int i = 0; i < nd; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 19) == 0) begin
      p = int'($urandom_range(0, nd - 1));
      v[4*p +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  // Issue one start pulse, then scramble the operand inputs while the op runs.
  task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (sel == 4) begin
      a4 = a[15:0];
      b4 = b[15:0];
      start4 = 1'b1;
      q4.push_back(model(a, b, 4, cyc + 1));
    end else begin
      a1 = a[3:0];
      b1 = b[3:0];
      start1 = 1'b1;
      q1.push_back(model(a, b, 1, cyc + 1));
    end
    @(negedge clk);
    if (sel == 4) begin
      start4 = 1'b0;
      checkOutput("busy4_run", 32'(busy4), 32'd1);
      a4 = 16'($urandom);
      b4 = 16'($urandom);
    end else begin
      start1 = 1'b0;
      checkOutput("busy1_run", 32'(busy1), 32'd1);
      a1 = 4'($urandom);
      b1 = 4'($urandom);
    end
  endtask

  task automatic waitIdle(input int sel);
    int n = 0;
    while (((sel == 4) ? q4.size() : q1.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput((sel == 4) ? "timeout4" : "timeout1", 32'(n < 100), 32'd1);
    if (sel == 4) q4.delete(); else q1.delete();
    @(negedge clk);
  endtask

  // Monitors: pop and compare whenever a done pulse appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done4) begin
        checkOutput("done4_pulse", 32'(prev_done4), 32'd0);
        checkOutput("busy4_at_done", 32'(busy4), 32'd0);
        checkOutput("done4_expected", 32'(q4.size() != 0), 32'd1);
        if (q4.size() != 0) begin
          got4 = q4.pop_front();
          checkOutput("res4", 32'(res4), got4.res);
          checkOutput("brw4", 32'(brw4), 32'(got4.brw));
          checkOutput("err4", 32'(err4), 32'(got4.err));
          checkOutput("lat4", 32'(cyc), 32'(got4.cyc));
        end
      end
      prev_done4 <= done4;
    end else begin
      prev_done4 <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done1) begin
        checkOutput("done1_pulse", 32'(prev_done1), 32'd0);
        checkOutput("busy1_at_done", 32'(busy1), 32'd0);
        checkOutput("done1_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          got1 = q1.pop_front();
          checkOutput("res1", 32'(res1), got1.res);
          checkOutput("brw1", 32'(brw1), 32'(got1.brw));
          checkOutput("err1", 32'(err1), 32'(got1.err));
          checkOutput("lat1", 32'(cyc), 32'(got1.cyc));
        end
      end
      prev_done1 <= done1;
    end else begin
      prev_done1 <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] dir_a [5] = '{32'h0052, 32'h0017, 32'h0000, 32'h9999, 32'h00A1};
    logic [31:0] dir_b [5] = '{32'h0017, 32'h0052, 32'h0001, 32'h9999, 32'h0001};
    logic [31:0] dir_r [5] = '{32'h0035, 32'h9965, 32'h9999, 32'h0000, 32'h0000};
    int base;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy4", 32'(busy4), 32'd0);
    checkOutput("rst_done4", 32'(done4), 32'd0);
    checkOutput("rst_res4", 32'(res4), 32'd0);
    checkOutput("rst_brw4", 32'(brw4), 32'd0);
    checkOutput("rst_err4", 32'(err4), 32'd0);
    checkOutput("rst_busy1", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(4, dir_a[i], dir_b[i]);
      waitIdle(4);
      repeat (2) @(negedge clk);
      checkOutput("dir_res_hold", 32'(res4), dir_r[i]);
    end

    // Start held high for 20 cycles: accepted every DIGITS+2 cycles.
    @(negedge clk);
    a4 = 16'h0352;
    b4 = 16'h0117;
    start4 = 1'b1;
    base = cyc + 1;
    for (int k = 0; k < 4; k++) q4.push_back(model(32'h0352, 32'h0117, 4, base + 6 * k));
    repeat (20) @(negedge clk);
    start4 = 1'b0;
    waitIdle(4);

    // Reset two cycles into an operation.
    @(negedge clk);
    a4 = 16'h4321;
    b4 = 16'h1234;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy4", 32'(busy4), 32'd0);
    checkOutput("abort_done4", 32'(done4), 32'd0);
    checkOutput("abort_res4", 32'(res4), 32'd0);
    checkOutput("abort_brw4", 32'(brw4), 32'd0);
    checkOutput("abort_err4", 32'(err4), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(4, 32'h4321, 32'h1234);
    waitIdle(4);
    checkOutput("after_reset_res4", 32'(res4), 32'h3087);

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          applyStimulus(4, randBcd(4), randBcd(4));
          waitIdle(4);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          applyStimulus(1, randBcd(1), randBcd(1));
          waitIdle(1);
        end
      end
    join

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_sub_serial.md
BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits per operand (legal range 1..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled on rising edge of clk.
REQ-005 SHALL have port a  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 SHALL have port b  input  4*DIGITS  subtrahend, packed BCD, same packing.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; marks result, borrow and err as valid.
REQ-009 SHALL have port result  output  4*DIGITS  packed BCD difference (a - b) mod 10^DIGITS.
REQ-010 SHALL have port borrow  output  1  high when a < b, i.e. result is the ten's complement.
REQ-011 SHALL have port err  output  1  high when any nibble of the captured a or b exceeds 9.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after DIGITS digit steps.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 SHALL capture a and b into internal registers on the edge where start=1 in IDLE, clear the digit index and the running borrow, and assert busy from that edge.
REQ-014 SHALL ignore start in RUN and DONE; captured operands are not disturbed, and a and b are don't-care after capture.
REQ-015 SHALL process one digit per RUN cycle, least-significant first:
- d = a_i - b_i - brw (5-bit signed arithmetic).
- If d < 0: digit = d + 10, brw_next = 1.
- Otherwise: digit = d, brw_next = 0.
REQ-016 SHALL shift or write each digit into the result register at its digit position; the digit index wraps nowhere and terminates at DIGITS-1.
REQ-017 SHALL enter DONE on the edge that writes digit DIGITS-1.
- Latency: start edge k, done=1 during the cycle after edge k+DIGITS.
- busy=1 from edge k through edge k+DIGITS inclusive.
- busy=0 in DONE.
REQ-018 SHALL drive borrow with the final brw from digit DIGITS-1.
REQ-019 SHALL evaluate err from the captured operands at capture time.
- If err=1, result SHALL read all zeros and borrow 0 at done; latency is unchanged.
REQ-020 SHALL hold result, borrow and err stable from done until the next accepted start, which clears them to 0.
REQ-021 SHALL accept start in IDLE on the cycle immediately after DONE (back-to-back ops, DIGITS+2 cycles per op).
REQ-022 SHALL produce done only as a single-cycle pulse, never two consecutive cycles.

Reset
REQ-023 SHALL, on rst_n=0 and asynchronously:
- force state IDLE;
- force busy=0, done=0, result=0, borrow=0, err=0;
- clear operand, index and brw registers.
REQ-024 SHALL abort any in-flight operation on reset with no done pulse; after rst_n rises, the first start edge begins a fresh operation.

Verification
REQ-025 a=0x0052, b=0x0017, start pulse -> done 5 cycles later (DIGITS=4), result=0x0035, borrow=0, err=0.
REQ-026 a=0x0017, b=0x0052 -> result=0x9965, borrow=1; a=0x0000, b=0x0001 -> result=0x9999, borrow=1; a=0x9999, b=0x9999 -> result=0x0000, borrow=0.
REQ-027 a=0x00A1, b=0x0001 -> err=1, result=0x0000, borrow=0, done at the normal latency.
REQ-028 start held high continuously for 20 cycles with constant operands -> done every 6 cycles; operands changed mid-RUN do not alter that operation's result.
REQ-029 rst_n pulsed low 2 cycles after start -> busy and all outputs 0 immediately, no done; the next start yields the correct result.
REQ-030 Random valid BCD operands (>=1000 ops, DIGITS=4 and DIGITS=1) -> result and borrow match a reference model of (a-b) mod 10^DIGITS with a<b flag.
